dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder for the KGP-RISC core's load/store port: the memory-side end of the MemRead/MemWrite path.
//   Accepts one word request at a time over a valid/ready handshake and services it from an internal word-addressed RAM.
//   Wait-state latency is programmable. Returns load data or a store acknowledge as a one-cycle response pulse.
//   Sits between the core's load/store path and the MemToReg write-back mux.
// PARAMETERS
//   ADDR_WIDTH   10  word-index bits; RAM depth = 2**ADDR_WIDTH words
//   WAIT_CYCLES  2   wait-state cycles inserted between accept and response (0..15)
// PORTS
//   clk         in   1   single clock, rising edge
//   rst         in   1   synchronous, active-high reset
//   req_valid   in   1   core presents a request
//   req_ready   out  1   responder can accept (high only in IDLE)
//   req_write   in   1   1 = store, 0 = load
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data (ignored for loads)
//   resp_valid  out  1   one-cycle response pulse
//   resp_rdata  out  32  load data (0 for stores)
//   resp_err    out  1   address error, valid with resp_valid (0 without DMEM_ERR_CHECK_EN)
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, wait counter=0, req_ready=0 while rst is high, resp_valid=0, resp_rdata=0, resp_err=0.
//     RAM contents are not cleared. req_ready=1 in the first cycle after rst deasserts.
//   All outputs are registered. FSM states: IDLE, WAIT, RESP.
//   IDLE: req_ready=1. Accept on req_valid&&req_ready (cycle N): latch write/addr/wdata, drop req_ready.
//     WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES-1.
//     WAIT_CYCLES=0: go straight to RESP.
//   WAIT: counter decrements each cycle. At 0, go to RESP.
//   Commit: the RAM access happens on the edge entering RESP.
//     Store writes RAM[idx]. Load registers RAM[idx] into resp_rdata.
//   RESP: resp_valid=1 for exactly one cycle, in cycle N+1+WAIT_CYCLES. Then return to IDLE, req_ready=1 next cycle.
//   There is no response backpressure; the core always takes resp.
//   Throughput: one request per WAIT_CYCLES+2 cycles.
//   Word index idx = req_addr[ADDR_WIDTH+1:2].
//   resp_rdata holds its last value when resp_valid=0.
//   Stores return resp_rdata=0.
//   req_valid while req_ready=0 is ignored, not queued. The core holds the request until accepted.
//   A load following a store to the same idx returns the stored data.
//   rst during WAIT: request abandoned, no RAM write, no response.
//   rst in the commit cycle: rst wins and the write is suppressed.
// CONFIGURATION
//   DMEM_ERR_CHECK_EN defined: a request is an error if req_addr[1:0]!=0 or req_addr[31:ADDR_WIDTH+2]!=0.
//     On error: RAM is not written, resp_rdata=0, resp_err=1 with resp_valid. Latency is unchanged.
//   DMEM_ERR_CHECK_EN undefined: addr[1:0] and upper bits are ignored, so addresses alias and wrap modulo 2**(ADDR_WIDTH+2).
//     resp_err is tied to 0.
// TESTING
//   Reset: rst=1 for 2 cycles -> req_ready=0, resp_valid=0, resp_rdata=0 throughout; req_ready=1 the cycle after release.
//   WAIT_CYCLES=2, store 0xDEADBEEF @0x10 accepted at N -> resp_valid only at N+3 with rdata=0.
//     Then load @0x10 accepted at M -> resp_valid at M+3 with rdata=0xDEADBEEF.
//   req_valid held high across back-to-back loads, WAIT_CYCLES=2 -> accepts exactly 4 cycles apart, one resp_valid pulse each.
//     req_ready=0 for 3 cycles between accepts.
//   ADDR_WIDTH=10, no macro: store 0x12345678 @0x1000, load @0x0 -> rdata=0x12345678.
//     With macro: store @0x1000 -> resp_err=1, and load @0x0 returns the prior value.
//     With macro, load @0x6 -> resp_err=1, rdata=0.
//   Store 0xAAAA5555 @0x20 then store 0x0 @0x20 with rst pulsed in WAIT -> no resp_valid for the aborted store.
//     Load @0x20 -> rdata=0xAAAA5555.
//   WAIT_CYCLES=0: load accepted at N -> resp_valid at N+1; sustained req_valid -> an accept every 2 cycles.

Source files
------------

// File: rtl/dmem_if.sv
// Load/store request and response bundle between the core and the data-memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM answering one load/store at a time after WAIT_CYCLES wait states.
// Optional address checking is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q, wdata_q;
  logic        req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  accept, commit, c_write, c_err;
  logic [31:0]           c_addr, c_wdata;
  logic [ADDR_WIDTH-1:0] c_idx;

  assign accept = (state_q == StIdle) && req_ready_q && bus.req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the access commits on the accept edge, before the request is latched.
  assign c_write = (state_q == StIdle) ? bus.req_write : write_q;
  assign c_addr  = (state_q == StIdle) ? bus.req_addr  : addr_q;
  assign c_wdata = (state_q == StIdle) ? bus.req_wdata : wdata_q;
  assign c_idx   = c_addr[ADDR_WIDTH+1:2];
  assign commit  = !rst && (state_d == StResp) && (state_q != StResp);

`ifdef DMEM_ERR_CHECK_EN
  assign c_err = (c_addr[1:0] != 2'b00) || ((c_addr >> (ADDR_WIDTH + 2)) != 32'd0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[31:ADDR_WIDTH+2], c_addr[1:0]};
  assign c_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= (state_d == StIdle);
      resp_valid_q <= commit;
      if (commit) begin
        resp_rdata_q <= (c_write || c_err) ? 32'd0 : mem[c_idx];
        resp_err_q   <= c_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
    if (commit && c_write && !c_err) mem[c_idx] <= c_wdata;
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed and random checks of dmem_responder against a word-array memory model,
// with a second zero-wait-state instance for latency and throughput.
module tb_dmem_responder;
  localparam int AW = 10;
  localparam int W2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if b2 ();
  dmem_if b0 ();

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0))  u_dut0 (.clk(clk), .rst(rst), .bus(b0));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [1024];
  bit          known [1024];
  logic [31:0] last_rd;
  logic        last_err;
  logic [31:0] init0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request on b2 and return one cycle after it is accepted.
  task automatic accept_only(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input string tag);
    int n = 0;
    b2.req_valid = 1'b1;
    b2.req_write = w;
    b2.req_addr  = a;
    b2.req_wdata = d;
    while (!b2.req_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, ":acc"}, {31'd0, b2.req_ready}, 32'd1);
    step();
    b2.req_valid = 1'b0;
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input string tag);
    logic        err_e;
    logic [31:0] rd_e;
    logic [9:0]  idx;
    bit          check_rd;
    int          lat;
`ifdef DMEM_ERR_CHECK_EN
    err_e = (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
`else
    err_e = 1'b0;
`endif
    idx      = a[AW+1:2];
    check_rd = 1'b1;
    rd_e     = 32'd0;
    if (w) begin
      if (!err_e) begin
        model[idx] = d;
        known[idx] = 1'b1;
      end
    end else if (!err_e) begin
      rd_e     = model[idx];
      check_rd = known[idx];
    end
    accept_only(w, a, d, tag);
    lat = 1;
    while (!b2.resp_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, ":lat"}, 32'(lat), 32'(W2 + 1));
    last_rd  = b2.resp_rdata;
    last_err = b2.resp_err;
    if (check_rd) chk({tag, ":rdata"}, b2.resp_rdata, rd_e);
    chk({tag, ":err"}, {31'd0, b2.resp_err}, {31'd0, err_e});
    step();
    chk({tag, ":pulse"}, {31'd0, b2.resp_valid}, 32'd0);
  endtask

  // Hold req_valid for win cycles; accepts must be gap apart, each answered gap-1 cycles later.
  task automatic thru(input bit sel, input int win, input int gap, input logic w,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd,
                      input string tag);
    int acc[$];
    int rsp[$];
    logic rdy, rv;
    logic [31:0] rd;
    if (sel) begin
      b0.req_valid = 1'b1; b0.req_write = w; b0.req_addr = a; b0.req_wdata = d;
    end else begin
      b2.req_valid = 1'b1; b2.req_write = w; b2.req_addr = a; b2.req_wdata = d;
    end
    for (int i = 0; i < win; i++) begin
      rdy = sel ? b0.req_ready  : b2.req_ready;
      rv  = sel ? b0.resp_valid : b2.resp_valid;
      rd  = sel ? b0.resp_rdata : b2.resp_rdata;
      if (rdy) acc.push_back(i);
      if (rv) begin
        rsp.push_back(i);
        chk({tag, ":rdata"}, rd, exp_rd);
      end
      step();
    end
    b0.req_valid = 1'b0;
    b2.req_valid = 1'b0;
    chk({tag, ":n_acc"}, 32'(acc.size()), 32'(win / gap));
    chk({tag, ":n_rsp"}, 32'(rsp.size()), 32'(win / gap));
    for (int k = 0; k < acc.size() && k < rsp.size(); k++) begin
      chk({tag, ":acc_at"}, 32'(acc[k]), 32'(k * gap));
      chk({tag, ":rsp_at"}, 32'(rsp[k]), 32'(acc[k] + gap - 1));
    end
  endtask

  task automatic watch_quiet(input string tag);
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (b2.resp_valid) pulses++;
      step();
    end
    chk({tag, ":no_resp"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_ready",  {31'd0, b2.req_ready},  32'd0);
      chk("rst_rvalid", {31'd0, b2.resp_valid}, 32'd0);
      chk("rst_rdata",  b2.resp_rdata,          32'd0);
      chk("rst_err",    {31'd0, b2.resp_err},   32'd0);
    end
    rst = 1'b0;
    step();
    chk("rel_ready",  {31'd0, b2.req_ready}, 32'd1);
    chk("rel_ready0", {31'd0, b0.req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) xact(1'b1, 32'(i * 4), $urandom, "init");
    init0 = model[0];

    xact(1'b1, 32'h10, 32'hDEADBEEF, "st10");
    chk("st10_rd0", last_rd, 32'd0);
    xact(1'b0, 32'h10, 32'd0, "ld10");
    chk("ld10_val", last_rd, 32'hDEADBEEF);

    xact(1'b1, 32'h1000, 32'h12345678, "st1000");
    xact(1'b0, 32'h0, 32'd0, "ld0");
`ifdef DMEM_ERR_CHECK_EN
    chk("ld0_prior", last_rd, init0);
`else
    chk("ld0_alias", last_rd, 32'h12345678);
`endif
    xact(1'b0, 32'h6, 32'd0, "ld6");
`ifdef DMEM_ERR_CHECK_EN
    chk("ld6_err", {31'd0, last_err}, 32'd1);
    chk("ld6_rd",  last_rd, 32'd0);
`endif

    xact(1'b1, 32'h20, 32'hAAAA5555, "st20");
    accept_only(1'b1, 32'h20, 32'h0, "abort_wait");
    rst = 1'b1;
    step();
    rst = 1'b0;
    watch_quiet("abort_wait");
    accept_only(1'b1, 32'h20, 32'h11111111, "abort_commit");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    watch_quiet("abort_commit");
    xact(1'b0, 32'h20, 32'd0, "ld20");
    chk("ld20_val", last_rd, 32'hAAAA5555);

    thru(1'b0, 12, W2 + 2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, "b2b");
    thru(1'b1, 6, 2, 1'b1, 32'h40, 32'h5A5A5A5A, 32'd0, "w0st");
    thru(1'b1, 6, 2, 1'b0, 32'h40, 32'd0, 32'h5A5A5A5A, "w0ld");

    for (int k = 0; k < 40; k++) begin
      w = 1'(($urandom_range(0, 1)));
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) a[31:12] = 20'($urandom_range(1, 3));
      xact(w, a, $urandom, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
